// File: rtl/rv_pkg.sv
// Package for the fetch/decode stage.
// Holds the opcode, funct3 and funct7 encodings of the supported instructions
// (add, addi, bne), the ALU control encoding, and ctrl_t, which bundles the
// per-instruction datapath controls produced by the decoder.
package rv_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;   // register-register ALU
   localparam logic [6:0] OP_I   = 7'b0010011;   // register-immediate ALU
   localparam logic [6:0] OP_B   = 7'b1100011;   // conditional branch

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [6:0] F7_ADD = 7'b0000000;

   localparam int         ALU_CTRL_W = 3;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;

   typedef struct packed {
      logic                  reg_write;   // raw write enable, before valid/stall gating
      logic                  alu_src;     // 1 = immediate is operand 2
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic                  is_bne;
   } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Ports:
//   instr    in   DATA_WIDTH          instruction word
//   ctrl     out  ctrl_t              write enable, operand select, ALU op, bne flag
//   imm      out  DATA_WIDTH          sign-extended immediate (0 for add/illegal)
//   illegal  out  1                   word is not add/addi/bne (not gated by valid)
//   rs1/rs2/rd out REG_ADDRESS_WIDTH  raw register index fields
module instr_decoder
   import rv_pkg::*;
#(
   parameter int REG_ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH        = 32
) (
   input  logic [DATA_WIDTH-1:0]        instr,
   output ctrl_t                        ctrl,
   output logic [DATA_WIDTH-1:0]        imm,
   output logic                         illegal,
   output logic [REG_ADDRESS_WIDTH-1:0] rs1,
   output logic [REG_ADDRESS_WIDTH-1:0] rs2,
   output logic [REG_ADDRESS_WIDTH-1:0] rd
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Register fields are passed through regardless of format; the datapath
   // ignores the ones an instruction does not use.
   assign rs1 = instr[15 +: REG_ADDRESS_WIDTH];
   assign rs2 = instr[20 +: REG_ADDRESS_WIDTH];
   assign rd  = instr[7  +: REG_ADDRESS_WIDTH];

   always_comb begin
      ctrl.reg_write = 1'b0;
      ctrl.alu_src   = 1'b0;
      ctrl.alu_ctrl  = ALU_ADD;
      ctrl.is_bne    = 1'b0;
      imm            = '0;
      illegal        = 1'b1;

      case (opcode)
         OP_R: begin
            if (funct3 == F3_ADD && funct7 == F7_ADD) begin
               illegal        = 1'b0;
               ctrl.reg_write = 1'b1;
            end
         end
         OP_I: begin
            if (funct3 == F3_ADD) begin
               illegal        = 1'b0;
               ctrl.reg_write = 1'b1;
               ctrl.alu_src   = 1'b1;
               imm            = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
            end
         end
         OP_B: begin
            if (funct3 == F3_BNE) begin
               illegal       = 1'b0;
               ctrl.alu_ctrl = ALU_SUB;
               ctrl.is_bne   = 1'b1;
               // B-type offset is scattered and always even.
               imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage feeding the register-file/ALU datapath.
// Owns the fetch PC, drives a synchronous (1-cycle latency) instruction ROM and
// decodes the returned word. bne is resolved in decode from the datapath EQ
// flag; a taken branch redirects fetch and squashes the one wrong-path word.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   imem_addr       ROM byte address (data returns next cycle)
//   imem_rdata      ROM read data = decode-stage instruction
//   stall           hold decode stage, no PC advance, RegWrite forced low
//   EQ              datapath equality flag for the decode-stage instruction
//   d_valid, d_pc   decode stage holds a real instruction / its PC
//   ImmOp, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, illegal  decoded controls
module fetch_decode
   import rv_pkg::*;
#(
   parameter int MEM_ADDRESS_WIDTH = 8,
   parameter int REG_ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH        = 32,
   parameter logic [MEM_ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [MEM_ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]        imem_rdata,
   input  logic                         stall,
   input  logic                         EQ,
   output logic                         d_valid,
   output logic [MEM_ADDRESS_WIDTH-1:0] d_pc,
   output logic [DATA_WIDTH-1:0]        ImmOp,
   output logic [REG_ADDRESS_WIDTH-1:0] rs1,
   output logic [REG_ADDRESS_WIDTH-1:0] rs2,
   output logic [REG_ADDRESS_WIDTH-1:0] rd,
   output logic                         RegWrite,
   output logic                         ALUsrc,
   output logic [ALU_CTRL_W-1:0]        ALUctrl,
   output logic                         illegal
);

   logic [MEM_ADDRESS_WIDTH-1:0] fetch_pc;
   logic [MEM_ADDRESS_WIDTH-1:0] f_pc_q;     // address issued last cycle = decode PC
   logic                         f_valid_q;

   ctrl_t ctrl;
   logic  dec_illegal;
   logic  br_taken;
   logic [MEM_ADDRESS_WIDTH-1:0] br_target;

   instr_decoder #(
      .REG_ADDRESS_WIDTH (REG_ADDRESS_WIDTH),
      .DATA_WIDTH        (DATA_WIDTH)
   ) u_dec (
      .instr   (imem_rdata),
      .ctrl    (ctrl),
      .imm     (ImmOp),
      .illegal (dec_illegal),
      .rs1     (rs1),
      .rs2     (rs2),
      .rd      (rd)
   );

   assign d_valid  = f_valid_q;
   assign d_pc     = f_pc_q;
   assign ALUsrc   = ctrl.alu_src;
   assign ALUctrl  = ctrl.alu_ctrl;
   assign RegWrite = f_valid_q & ctrl.reg_write & ~stall;
   assign illegal  = f_valid_q & dec_illegal;

   // Re-issuing the decode PC during a stall makes the ROM return the same
   // word next cycle, so the decode outputs stay frozen without a holding reg.
   assign imem_addr = stall ? f_pc_q : fetch_pc;

   assign br_taken  = f_valid_q & ctrl.is_bne & ~EQ & ~stall;
   assign br_target = f_pc_q + ImmOp[MEM_ADDRESS_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         f_pc_q    <= RESET_PC;
         f_valid_q <= 1'b0;
      end else if (!stall) begin
         f_pc_q <= fetch_pc;
         if (br_taken) begin
            // The word fetched this cycle is wrong-path: mark it as a bubble.
            fetch_pc  <= br_target;
            f_valid_q <= 1'b0;
         end else begin
            fetch_pc  <= fetch_pc + MEM_ADDRESS_WIDTH'(4);
            f_valid_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

   logic        clk = 1'b0;
   logic        rst, stall, EQ;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        d_valid;
   logic [7:0]  d_pc;
   logic [31:0] ImmOp;
   logic [4:0]  rs1, rs2, rd;
   logic        RegWrite, ALUsrc, illegal;
   logic [2:0]  ALUctrl;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] rom [0:63];

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= rom[imem_addr[7:2]];

   fetch_decode dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .EQ(EQ), .d_valid(d_valid), .d_pc(d_pc), .ImmOp(ImmOp),
      .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
      .ALUctrl(ALUctrl), .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic exp_ill, exp_rw;
      // Background program: addi x(i%32), x0, i at word i.
      for (int i = 0; i < 64; i++) rom[i] = (i << 20) | ((i % 32) << 7) | 32'h13;
      rom[0]  = 32'h00500093;   // addi x1,x0,5
      rom[1]  = 32'hFFF00113;   // addi x2,x0,-1
      rom[4]  = 32'hFE209CE3;   // 0x10: bne x1,x2,-8
      rom[8]  = 32'hFE209CE3;   // 0x20: bne x1,x2,-8
      rom[12] = 32'h00000000;   // 0x30: illegal
      rom[13] = 32'h002081B3;   // 0x34: add x3,x1,x2
      rom[14] = 32'h402081B3;   // 0x38: sub (unsupported funct7)

      rst = 1'b1; stall = 1'b0; EQ = 1'b1;
      step(); step();
      chk("rst_dvalid", d_valid, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_regwrite", RegWrite, 0);
      chk("rst_illegal", illegal, 0);

      rst = 1'b0;
      step();
      chk("first_dvalid", d_valid, 1);
      chk("first_dpc", d_pc, 0);
      chk("first_addr", imem_addr, 4);
      chk("addi_rd", rd, 1);
      chk("addi_rs1", rs1, 0);
      chk("addi_imm", ImmOp, 5);
      chk("addi_alusrc", ALUsrc, 1);
      chk("addi_regwrite", RegWrite, 1);
      chk("addi_aluctrl", ALUctrl, 0);
      chk("addi_illegal", illegal, 0);

      step();
      chk("neg_dpc", d_pc, 4);
      chk("neg_imm", ImmOp, 32'hFFFFFFFF);
      chk("neg_addr", imem_addr, 8);

      step(); step(); step();
      chk("bne_dpc", d_pc, 8'h10);
      chk("bne_aluctrl", ALUctrl, 1);
      chk("bne_regwrite", RegWrite, 0);
      chk("bne_alusrc", ALUsrc, 0);
      chk("bne_imm", ImmOp, 32'hFFFFFFF8);
      chk("bne_rs1", rs1, 1);
      chk("bne_rs2", rs2, 2);
      chk("bne_addr", imem_addr, 8'h14);

      EQ = 1'b0;                          // taken
      step();
      chk("taken_bubble", d_valid, 0);
      chk("taken_addr", imem_addr, 8'h08);
      chk("bubble_regwrite", RegWrite, 0);
      EQ = 1'b1;
      step();
      chk("target_dvalid", d_valid, 1);
      chk("target_dpc", d_pc, 8'h08);

      step(); step();
      chk("bne2_dpc", d_pc, 8'h10);      // EQ=1: not taken
      step();
      chk("nt_dvalid", d_valid, 1);
      chk("nt_dpc", d_pc, 8'h14);
      chk("nt_addr", imem_addr, 8'h18);

      step(); step();
      chk("pre_stall_dpc", d_pc, 8'h1C);
      stall = 1'b1; #1;
      chk("stall_regwrite", RegWrite, 0);
      chk("stall_addr", imem_addr, 8'h1C);
      step();
      chk("stall_hold_dpc", d_pc, 8'h1C);
      chk("stall_hold_imm", ImmOp, 7);
      stall = 1'b0; #1;
      chk("unstall_regwrite", RegWrite, 1);
      chk("unstall_addr", imem_addr, 8'h20);

      step();
      chk("bne3_dpc", d_pc, 8'h20);
      EQ = 1'b0; stall = 1'b1; #1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("sbr_dpc", d_pc, 8'h20);
         chk("sbr_dvalid", d_valid, 1);
         chk("sbr_addr", imem_addr, 8'h20);
         chk("sbr_regwrite", RegWrite, 0);
         chk("sbr_imm", ImmOp, 32'hFFFFFFF8);
      end
      stall = 1'b0; #1;
      chk("sbr_release_addr", imem_addr, 8'h24);
      step();
      chk("sbr_bubble", d_valid, 0);
      chk("sbr_target_addr", imem_addr, 8'h18);
      EQ = 1'b1;
      step();
      chk("sbr_target_dpc", d_pc, 8'h18);
      chk("sbr_target_dvalid", d_valid, 1);

      // Sequential run to the top of the ROM.
      for (int a = 8'h1C; a <= 8'hFC; a += 4) begin
         step();
         exp_ill = (a == 8'h30) || (a == 8'h38);
         exp_rw  = !(exp_ill || a == 8'h20);
         chk("seq_dpc", d_pc, 32'(a));
         chk("seq_illegal", illegal, {31'b0, exp_ill});
         chk("seq_regwrite", RegWrite, {31'b0, exp_rw});
         if (a == 8'h34) begin
            chk("add_alusrc", ALUsrc, 0);
            chk("add_rd", rd, 3);
            chk("add_imm", ImmOp, 0);
         end
      end
      chk("wrap_addr", imem_addr, 8'h00);
      step();
      chk("wrap_dpc", d_pc, 8'h00);
      chk("wrap_dvalid", d_valid, 1);

      step(); step(); step(); step();
      chk("rbr_dpc", d_pc, 8'h10);
      EQ = 1'b0; rst = 1'b1; stall = 1'b1;
      step();
      chk("rbr_dvalid", d_valid, 0);
      chk("rbr_addr", imem_addr, 8'h00);
      chk("rbr_regwrite", RegWrite, 0);
      chk("rbr_illegal", illegal, 0);
      rst = 1'b0; EQ = 1'b1; stall = 1'b0;
      step();
      chk("rbr_after_dvalid", d_valid, 1);
      chk("rbr_after_dpc", d_pc, 8'h00);
      chk("rbr_after_addr", imem_addr, 8'h04);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
